// File: rtl/rv_pkg.sv
// Shared RV32 definitions used by the fetch front end: widths, major opcodes,
// the canonical NOP and the fetch-unit state encoding.
package rv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] LOAD   = 7'b000_0011;
    localparam logic [6:0] OP_IMM = 7'b001_0011;
    localparam logic [6:0] AUIPC  = 7'b001_0111;
    localparam logic [6:0] STORE  = 7'b010_0011;
    localparam logic [6:0] LUI    = 7'b011_0111;
    localparam logic [6:0] BRANCH = 7'b110_0011;
    localparam logic [6:0] JALR   = 7'b110_0111;
    localparam logic [6:0] JAL    = 7'b110_1111;

    localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FETCH,
        FLUSH
    } ifu_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a synchronous clear that
// dominates push and pop. A push while full is accepted only with a pop.
module sync_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign wr_en = push_i && (!full_o || pop_i) && !clr_i;
    assign rd_en = pop_i && !empty_o && !clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(wr_en) - CntW'(rd_en);
        if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// In-order instruction fetch: credit-limited memory requests, FWFT buffer to decode,
// redirect flush. Optional misaligned-redirect trap under IFU_MISALIGN_CHK_EN.
module instruction_fetch_unit
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH      = 2,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] inst_pc
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic            fetch_misaligned
`endif
);

    localparam int unsigned CntW     = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int unsigned InstCntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TagCntW  = $clog2(MAX_OUTSTANDING + 1);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
    logic            fetch_en_q;
    logic            req_block;

    logic                  req_accept;
    logic                  rsp_ok;
    logic                  rsp_keep;
    logic                  inst_empty;
    logic                  inst_full;
    logic [InstCntW-1:0]   inst_count;
    logic [2*XLEN-1:0]     inst_head;
    logic                  tag_empty;
    logic                  tag_full;
    logic [TagCntW-1:0]    tag_count;
    logic [XLEN-1:0]       tag_head;
    logic                  unused_fifo_status;

`ifdef IFU_MISALIGN_CHK_EN
    logic misaligned_q, misaligned_d;
    assign req_block        = misaligned_q;
    assign fetch_misaligned = misaligned_q;
`else
    logic [1:0] unused_redirect_lsb;
    assign req_block           = 1'b0;
    assign unused_redirect_lsb = redirect_pc[1:0];
`endif

    // Credits: words in flight plus words buffered must fit in the buffer.
    assign imem_req_valid = fetch_en_q && !req_block
                         && ((outstanding_q + CntW'(inst_count)) < CntW'(FIFO_DEPTH))
                         && (outstanding_q < CntW'(MAX_OUTSTANDING));
    assign imem_req_addr  = fetch_pc_q;

    assign req_accept = imem_req_valid && imem_req_ready;
    assign rsp_ok     = imem_rsp_valid && (outstanding_q != '0);
    assign rsp_keep   = rsp_ok && (state_q == FETCH) && !redirect_valid;

    assign inst_valid  = !inst_empty;
    assign instruction = inst_empty ? INST_NOP : inst_head[XLEN-1:0];
    assign inst_pc     = inst_empty ? fetch_pc_q : inst_head[2*XLEN-1:XLEN];

    assign unused_fifo_status = ^{inst_full, tag_empty, tag_full, tag_count};

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CntW'(req_accept) - CntW'(rsp_ok);
`ifdef IFU_MISALIGN_CHK_EN
        misaligned_d  = misaligned_q;
`endif
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
`ifdef IFU_MISALIGN_CHK_EN
            misaligned_d = (redirect_pc[1:0] != 2'b00);
            if (misaligned_d) fetch_pc_d = redirect_pc;
`endif
            // Everything still owed by memory after this edge belongs to the old stream.
            drop_cnt_d = outstanding_d;
            state_d    = (outstanding_d != '0) ? FLUSH : FETCH;
        end else begin
            if (req_accept) fetch_pc_d = fetch_pc_q + 32'd4;
            if (state_q == FLUSH && rsp_ok) begin
                drop_cnt_d = drop_cnt_q - CntW'(1);
                state_d    = (drop_cnt_d == '0) ? FETCH : FLUSH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fetch_en_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fetch_en_q    <= 1'b1;
        end
    end

`ifdef IFU_MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) misaligned_q <= 1'b0;
        else     misaligned_q <= misaligned_d;
    end
`endif

    sync_fifo #(
        .Width (XLEN),
        .Depth (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (redirect_valid),
        .push_i  (req_accept),
        .wdata_i (fetch_pc_q),
        .pop_i   (rsp_keep),
        .rdata_o (tag_head),
        .empty_o (tag_empty),
        .full_o  (tag_full),
        .count_o (tag_count)
    );

    sync_fifo #(
        .Width (2 * XLEN),
        .Depth (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (redirect_valid),
        .push_i  (rsp_keep),
        .wdata_i ({tag_head, imem_rsp_data}),
        .pop_i   (inst_ready),
        .rdata_o (inst_head),
        .empty_o (inst_empty),
        .full_o  (inst_full),
        .count_o (inst_count)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised bench for instruction_fetch_unit: an in-order memory with random latency
// and a stream-level model of which words decode must see, in which order.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        inst_valid;
    logic        inst_ready     = 1'b0;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
`ifdef IFU_MISALIGN_CHK_EN
    logic        fetch_misaligned;
`endif

    always #5 clk = ~clk;

    instruction_fetch_unit #(
        .RESET_PC        (RESET_PC),
        .FIFO_DEPTH      (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc)
`ifdef IFU_MISALIGN_CHK_EN
        ,
        .fetch_misaligned (fetch_misaligned)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          epoch;
        int          due;
    } req_t;

    req_t        pend_q[$];
    logic [31:0] fifo_q[$];
    int          epoch    = 0;
    int          cyc      = 0;
    logic [31:0] exp_addr = RESET_PC;
    bit          armed    = 1'b0;
    bit          misal    = 1'b0;

    int rdy_pct   = 100;
    int irdy_pct  = 100;
    int lat_min   = 1;
    int lat_max   = 1;
    int redir_pct = 0;
    bit          redir_on_both = 1'b0;
    logic [31:0] both_tgt      = '0;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_req_valid", imem_req_valid, 0);
        check_eq("rst_req_addr", imem_req_addr, RESET_PC);
        check_eq("rst_inst_valid", inst_valid, 0);
        check_eq("rst_instruction", instruction, NOP);
        check_eq("rst_inst_pc", inst_pc, RESET_PC);
`ifdef IFU_MISALIGN_CHK_EN
        check_eq("rst_misaligned", fetch_misaligned, 0);
`endif
    endtask

    // One clock: called and returns at a negedge.
    task automatic step(input bit redir_in, input logic [31:0] tgt_in);
        bit          acc, pop, rsp, redir, exp_vld;
        logic [31:0] tgt;
        req_t        h;
        redir = redir_in;
        tgt   = tgt_in;

        exp_vld = armed && !misal && (pend_q.size() + fifo_q.size() < DEPTH)
               && (pend_q.size() < MAX_OUT);
        check_eq("req_valid", imem_req_valid, exp_vld);
        if (imem_req_valid) check_eq("req_addr", imem_req_addr, exp_addr);
        check_eq("inst_valid", inst_valid, fifo_q.size() != 0);
        if (inst_valid && fifo_q.size() != 0) begin
            check_eq("inst_pc", inst_pc, fifo_q[0]);
            check_eq("instruction", instruction, mem_word(fifo_q[0]));
        end
`ifdef IFU_MISALIGN_CHK_EN
        check_eq("misaligned", fetch_misaligned, misal);
`endif

        imem_req_ready = ($urandom_range(99) < rdy_pct);
        inst_ready     = ($urandom_range(99) < irdy_pct);
        rsp            = (pend_q.size() != 0) && (pend_q[0].due <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(pend_q[0].addr) : $urandom;
        acc = imem_req_valid && imem_req_ready;
        pop = inst_valid && inst_ready;
        if (redir_on_both && acc && rsp) begin
            redir         = 1'b1;
            tgt           = both_tgt;
            redir_on_both = 1'b0;
        end
        redirect_valid = redir;
        redirect_pc    = redir ? tgt : $urandom;
        assert (!(imem_rsp_valid && pend_q.size() == 0))
            else $error("protocol violation: response with nothing outstanding");

        @(posedge clk);
        if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (rsp) begin
            h = pend_q.pop_front();
            if (!redir && h.epoch == epoch) fifo_q.push_back(h.pc);
        end
        if (acc) pend_q.push_back('{imem_req_addr, exp_addr, epoch,
                                    cyc + $urandom_range(lat_max, lat_min)});
        if (redir) begin
            fifo_q.delete();
            epoch++;
`ifdef IFU_MISALIGN_CHK_EN
            misal    = (tgt[1:0] != 2'b00);
            exp_addr = misal ? tgt : {tgt[31:2], 2'b00};
`else
            exp_addr = {tgt[31:2], 2'b00};
`endif
        end else if (acc) begin
            exp_addr = exp_addr + 32'd4;
        end
        armed = 1'b1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    task automatic apply_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        pend_q.delete();
        fifo_q.delete();
        epoch++;
        exp_addr = RESET_PC;
        armed    = 1'b0;
        misal    = 1'b0;
        #2;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(7) == 0) t[1:0] = 2'($urandom_range(3, 1));
        if ($urandom_range(9) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
        return t;
    endfunction

    initial begin
        @(negedge clk);
        apply_reset();

        // Streaming with an always-ready memory and decode.
        rdy_pct = 100; irdy_pct = 100; lat_min = 1; lat_max = 1;
        run(20);

        // Decode stalls: credits run out, nothing is lost.
        irdy_pct = 0;
        run(10);
        irdy_pct = 100;
        run(10);

        // Two requests in flight, then a redirect.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && pend_q.size() != 2; i++) step(1'b0, 32'h0);
        check_eq("two_inflight", pend_q.size(), 2);
        step(1'b1, 32'h0000_0100);
        run(15);

        // Redirect coinciding with a request accept and a response.
        lat_min = 1; lat_max = 1;
        both_tgt      = 32'h0000_0240;
        redir_on_both = 1'b1;
        for (int i = 0; i < 20 && redir_on_both; i++) step(1'b0, 32'h0);
        check_eq("redir_both_hit", redir_on_both, 0);
        run(10);

        // Address wrap at the top of memory.
        step(1'b1, 32'hFFFF_FFF8);
        run(10);

        // Misaligned redirect, then an aligned one.
        step(1'b1, 32'h0000_0102);
        run(8);
        step(1'b1, 32'h0000_0200);
        run(8);

        // Reset in the middle of traffic.
        lat_min = 2; lat_max = 4;
        run(5);
        apply_reset();
        run(12);

        // Randomised traffic.
        for (int blk = 0; blk < 15; blk++) begin
            rdy_pct   = $urandom_range(100, 30);
            irdy_pct  = $urandom_range(100, 30);
            lat_min   = $urandom_range(2, 1);
            lat_max   = lat_min + $urandom_range(3);
            redir_pct = $urandom_range(6);
            for (int i = 0; i < 200; i++) begin
                step($urandom_range(99) < redir_pct, rand_tgt());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
